// File: rtl/farm_road_request_detector_if.sv
// Farm-road request detector handshake bundle.
// Signals: sensor_raw, grant in; request, serving, car_count, queue_full out.
interface farm_road_request_detector_if #(
   parameter int CNT_W = 4
);
   logic             sensor_raw;
   logic             grant;
   logic             request;
   logic             serving;
   logic [CNT_W-1:0] car_count;
   logic             queue_full;

   // Board/controller side.
   modport master (
      output sensor_raw, grant,
      input  request, serving, car_count, queue_full
   );

   // Detector side.
   modport slave (
      input  sensor_raw, grant,
      output request, serving, car_count, queue_full
   );
endinterface

// File: rtl/farm_road_request_detector.sv
// Farm-road sensor conditioner: sync, debounce, count and hold request.
// Ports: CLOCK_50, RESET (async high), bus (slave: sensor/grant in,
// request/serving/car_count/queue_full out). Macro: FARM_REQ_DEBOUNCE_EN.
module farm_road_request_detector #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SERVE_CYCLES    = 100000000,
   parameter int CNT_W           = 4
) (
   input logic                         CLOCK_50,
   input logic                         RESET,
   farm_road_request_detector_if.slave bus
);
   localparam int SV_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE, S_WAIT, S_SERVE, S_RELEASE
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q;
   logic             stable, stable_dly_q;
   logic             arrival_q;
   logic [SV_W-1:0]  tmr_q, tmr_d;
   logic             drain;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full_q;

`ifdef FARM_REQ_DEBOUNCE_EN
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic            stable_q, stable_d;
   logic [DB_W-1:0] db_q, db_d;

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES.
   always_comb begin
      stable_d = stable_q;
      db_d     = '0;
      if (sync2_q != stable_q) begin
         if (db_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
         end else begin
            db_d = db_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         stable_q <= 1'b0;
         db_q     <= '0;
      end else begin
         stable_q <= stable_d;
         db_q     <= db_d;
      end
   end

   assign stable = stable_q;
`else
   // Without filtering the second synchronizer flop is the stable level.
   assign stable = sync2_q;
`endif

   // Drain pulse ends each full serve interval; timer idles at zero.
   assign drain = (state_q == S_SERVE) &&
                  (tmr_q == SV_W'(SERVE_CYCLES - 1));

   always_comb begin
      tmr_d = tmr_q + 1'b1;
      if (state_q != S_SERVE || drain) begin
         tmr_d = '0;
      end
   end

   // Simultaneous arrival and drain cancel out.
   always_comb begin
      cnt_d = cnt_q;
      case ({arrival_q, drain})
         2'b10:   if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         2'b01:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (arrival_q) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.grant) state_d = S_SERVE;
         end
         S_SERVE: begin
            if (!bus.grant) begin
               state_d = S_WAIT;
            end else if (cnt_q == '0 && !stable) begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // Next count so an arrival in this very cycle is not lost.
            if (!bus.grant) begin
               state_d = (cnt_d != '0) ? S_WAIT : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_dly_q <= 1'b0;
         arrival_q    <= 1'b0;
         tmr_q        <= '0;
         cnt_q        <= '0;
         full_q       <= 1'b0;
         state_q      <= S_IDLE;
      end else begin
         sync1_q      <= bus.sensor_raw;
         sync2_q      <= sync1_q;
         stable_dly_q <= stable;
         arrival_q    <= stable & ~stable_dly_q;
         tmr_q        <= tmr_d;
         cnt_q        <= cnt_d;
         full_q       <= (cnt_d == CNT_MAX);
         state_q      <= state_d;
      end
   end

   assign bus.request    = (state_q == S_WAIT) || (state_q == S_SERVE);
   assign bus.serving    = (state_q == S_SERVE);
   assign bus.car_count  = cnt_q;
   assign bus.queue_full = full_q;
endmodule

// File: tb/tb_farm_road_request_detector.sv
// Self-checking bench for farm_road_request_detector.
// Vector table plus expected-value queue for serve sequences.
module tb_farm_road_request_detector;
   localparam int DB = 4;
   localparam int SC = 8;
   localparam int CW = 3;
`ifdef FARM_REQ_DEBOUNCE_EN
   localparam int DEFF = DB;
`else
   localparam int DEFF = 0;
`endif
   localparam int LAT = 3 + DEFF;

   typedef struct {
      int         k;
      logic [7:0] v;
   } exp_t;

   typedef struct {
      int         pulses;
      logic [7:0] v;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t sq[$];
   vec_t tbl[5];

   farm_road_request_detector_if #(.CNT_W(CW)) bus ();

   farm_road_request_detector #(
      .DEBOUNCE_CYCLES(DB),
      .SERVE_CYCLES   (SC),
      .CNT_W          (CW)
   ) dut (
      .CLOCK_50(clk),
      .RESET   (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mk(input logic r, input logic s,
                                     input logic f, input int c);
      logic [2:0] cc;
      cc = 3'(c);
      return {2'b00, r, s, f, cc};
   endfunction

   function automatic logic [7:0] outs();
      return {2'b00, bus.request, bus.serving, bus.queue_full,
              bus.car_count};
   endfunction

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%02h required=%02h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.sensor_raw = 1'b0;
      bus.grant      = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", outs(), mk(0, 0, 0, 0));
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic arrive(input int n);
      for (int i = 0; i < n; i++) begin
         bus.sensor_raw = 1'b1;
         repeat (8) @(negedge clk);
         bus.sensor_raw = 1'b0;
         repeat (8) @(negedge clk);
      end
   endtask

   // Grant drives SERVE entry at edge E; k counts samples after E+k.
   task automatic serve_run(input string nm, input int kmax,
                            input int s_on);
      exp_t e;
      bus.grant = 1'b1;
      for (int k = 0; k <= kmax; k++) begin
         @(negedge clk);
         while (sq.size() > 0 && sq[0].k == k) begin
            e = sq.pop_front();
            chk($sformatf("%s_k%0d", nm, k), outs(), e.v);
         end
         if (s_on >= 0 && k == s_on - 1) bus.sensor_raw = 1'b1;
         if (s_on >= 0 && k == s_on + 7) bus.sensor_raw = 1'b0;
      end
      chk({nm, "_leftover"}, 8'(sq.size()), 8'd0);
      sq.delete();
   endtask

   initial begin
      int   rise;
      logic [7:0] at_rise;
      logic seen;
      exp_t e;
      checks   = 0;
      failures = 0;
      rst            = 1'b1;
      bus.sensor_raw = 1'b1;
      bus.grant      = 1'b0;

      tbl[0] = '{1, mk(1, 0, 0, 1)};
      tbl[1] = '{2, mk(1, 0, 0, 3)};
      tbl[2] = '{3, mk(1, 0, 0, 6)};
      tbl[3] = '{1, mk(1, 0, 1, 7)};
      tbl[4] = '{2, mk(1, 0, 1, 7)};

      // Reset held with sensor high, then a fresh arrival.
      repeat (3) @(negedge clk);
      chk("rst_sensor_hi", outs(), mk(0, 0, 0, 0));
      rst     = 1'b0;
      rise    = -1;
      at_rise = '0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.request && rise < 0) begin
            rise    = n;
            at_rise = outs();
         end
      end
      chk("rst_req_latency", 8'(rise), 8'(LAT));
      chk("rst_first_count", at_rise, mk(1, 0, 0, 1));
      bus.sensor_raw = 1'b0;

      // Short pulses: rejected with filtering, accepted without.
      do_reset();
`ifdef FARM_REQ_DEBOUNCE_EN
      seen = 1'b0;
      for (int i = 0; i < 18; i++) begin
         bus.sensor_raw = (i < 3) || (i >= 5 && i < 8);
         @(negedge clk);
         if (bus.request || bus.car_count != '0) seen = 1'b1;
      end
      chk("bounce_never_req", {7'd0, seen}, 8'd0);
      chk("bounce_outs", outs(), mk(0, 0, 0, 0));
`else
      bus.sensor_raw = 1'b1;
      @(negedge clk);
      bus.sensor_raw = 1'b0;
      repeat (2) @(negedge clk);
      chk("nodb_pre", outs(), mk(0, 0, 0, 0));
      @(negedge clk);
      chk("nodb_pulse", outs(), mk(1, 0, 0, 1));
`endif

      // Queue and drain.
      do_reset();
      arrive(3);
      chk("q3_wait", outs(), mk(1, 0, 0, 3));
      sq.push_back('{0,  mk(1, 1, 0, 3)});
      sq.push_back('{7,  mk(1, 1, 0, 3)});
      sq.push_back('{8,  mk(1, 1, 0, 2)});
      sq.push_back('{15, mk(1, 1, 0, 2)});
      sq.push_back('{16, mk(1, 1, 0, 1)});
      sq.push_back('{23, mk(1, 1, 0, 1)});
      sq.push_back('{24, mk(1, 1, 0, 0)});
      sq.push_back('{25, mk(0, 0, 0, 0)});
      serve_run("drain", 25, -1);
      bus.grant = 1'b0;
      @(negedge clk);
      chk("release_idle", outs(), mk(0, 0, 0, 0));
      bus.grant = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_grant_ignored", outs(), mk(0, 0, 0, 0));
      bus.grant = 1'b0;

      // Saturation from the vector table.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sq.push_back('{0, tbl[i].v});
         arrive(tbl[i].pulses);
         e = sq.pop_front();
         chk($sformatf("sat_vec%0d", i), outs(), e.v);
      end

      // Drain alone, then arrival coinciding with the second drain.
      sq.push_back('{0,  mk(1, 1, 1, 7)});
      sq.push_back('{7,  mk(1, 1, 1, 7)});
      sq.push_back('{8,  mk(1, 1, 0, 6)});
      sq.push_back('{16, mk(1, 1, 0, 6)});
      sq.push_back('{24, mk(1, 1, 0, 5)});
      serve_run("simul", 24, 13 - DEFF);
      bus.grant = 1'b0;

      // Preemption keeps the count and restarts the serve timer.
      do_reset();
      arrive(2);
      sq.push_back('{0, mk(1, 1, 0, 2)});
      sq.push_back('{4, mk(1, 1, 0, 2)});
      serve_run("pre_a", 4, -1);
      bus.grant = 1'b0;
      @(negedge clk);
      chk("preempt_wait", outs(), mk(1, 0, 0, 2));
      sq.push_back('{0, mk(1, 1, 0, 2)});
      sq.push_back('{7, mk(1, 1, 0, 2)});
      sq.push_back('{8, mk(1, 1, 0, 1)});
      serve_run("pre_b", 8, -1);
      bus.grant = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/farm_road_request_detector.md
# farm_road_request_detector

Sensor-side front end for the highway/farm-road traffic light controller: it conditions the raw farm-road vehicle sensor into a clean, held vehicle request and releases that request only after the controller has granted the farm road and the queued vehicles have drained. It sits between the board switch (SW[0]) and the controller's car-present input, and consumes the controller's farm-road-green indication as its grant. A saturating waiting-vehicle counter is exported for HEX display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive CLOCK_50 cycles (10 ms) a synchronized sensor level must differ from the stable level before it is accepted; minimum 1
- SERVE_CYCLES, 100000000, CLOCK_50 cycles of grant per drained vehicle (2 s); minimum 1
- CNT_W, 4, width of the vehicle counter; saturates at 2^CNT_W-1

Ports:
- CLOCK_50  in  1  system clock, all flops rising-edge
- RESET  in  1  asynchronous, active-high reset; top level drives it from ~KEY[0]
- sensor_raw  in  1  raw, asynchronous, bouncing vehicle sensor (SW[0])
- grant  in  1  controller farm-road green (level)
- request  out  1  held vehicle request to controller
- serving  out  1  high while in SERVE
- car_count  out  CNT_W  vehicles waiting
- queue_full  out  1  car_count == 2^CNT_W-1

## Operation
- Input path: two-flop synchronizer (sync1, sync2) -> debouncer. Debounce counter clears whenever sync2 == stable; else increments; when it reaches DEBOUNCE_CYCLES-1 while still mismatched, stable <= sync2 and counter clears.
- arrival = registered one-cycle pulse on stable 0->1. Stable 1->0 generates nothing.
- drain = one-cycle internal pulse in SERVE when serve timer hits SERVE_CYCLES-1; timer clears on this pulse and on any SERVE entry.
- car_count: arrival alone +1 (held at max when full); drain alone -1 if count>0; arrival and drain in same cycle: unchanged.
- FSM (2-bit): IDLE, WAIT, SERVE, RELEASE.
  - IDLE: request=0. arrival -> WAIT.
  - WAIT: request=1. grant=1 -> SERVE.
  - SERVE: request=1, serving=1. grant=0 -> WAIT (preempted, count kept). Else count==0 and stable==0 -> RELEASE.
  - RELEASE: request=0. grant=0 -> WAIT if count>0, else IDLE. Arrivals still counted.
- grant in IDLE or WAIT-less states other than listed is ignored; unrequested grant never alters count.
- All outputs registered; request/serving decoded from state register.

## Timing
- Reset values: request 0, serving 0, car_count 0, queue_full 0, state IDLE, stable 0, sync1/sync2 0, both counters 0.
- Sensor latency: sensor_raw rising before edge 0 and held -> sync2 high after edge 1 -> stable high after edge 1+DEBOUNCE_CYCLES -> arrival high after edge 2+DEBOUNCE_CYCLES -> request and car_count updated after edge 3+DEBOUNCE_CYCLES.
- Bounces shorter than DEBOUNCE_CYCLES cycles are never accepted.
- grant to serving: one cycle. Drains at SERVE_CYCLES, 2*SERVE_CYCLES, ... cycles after SERVE entry.
- request deassert: one cycle after the condition count==0 && stable==0 is seen in SERVE.
- RESET asserted mid-operation: all state cleared immediately (asynchronous); released synchronously-usable on next edge; sensor already high at release produces a fresh arrival after full debounce.

## Configuration
- FARM_REQ_DEBOUNCE_EN defined: debouncer as above.
- Not defined: debouncer removed, stable <= sync2 every cycle; DEBOUNCE_CYCLES ignored; sensor-to-request latency becomes 3 cycles. Used for fast simulation and direct-switch bring-up.

## Test plan
Parameters DEBOUNCE_CYCLES=4, SERVE_CYCLES=8, CNT_W=3, macro defined unless stated.
- Reset: RESET high with sensor_raw=1 -> all outputs 0; release -> request rises exactly 7 cycles after release edge, car_count=1.
- Bounce: sensor_raw pulses high 3 cycles, low 2, high 3 -> no arrival, request stays 0.
- Queue and drain: 3 clean arrivals in IDLE/WAIT -> car_count=3; grant=1 -> serving next cycle; sensor low -> car_count 2,1,0 at 8,16,24 cycles; request 0 one cycle later; grant=0 -> IDLE.
- Saturation and simultaneity: 9 arrivals -> car_count=7, queue_full=1; arrival coinciding with drain -> count unchanged.
- Preemption: grant drops in SERVE with car_count=2 -> WAIT, request stays 1, count 2; grant again -> serve timer restarts at 0.
- Macro undefined: single-cycle-stable sensor_raw high -> request after 3 cycles, car_count=1.
